pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined ripple-carry adder with valid/ready handshake. It is the sequential successor of the team's single-bit full adder. It adds two WIDTH-bit operands plus carry-in, splitting the carry chain into STAGES equal segments with one register boundary per segment. It accepts one operation per cycle and sits between operand producers and any consumer that can apply backpressure.

## Interface
- WIDTH, 32: operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4: pipeline depth, equal to the number of carry segments; 1 ≤ STAGES ≤ WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  adder accepts a beat this cycle.
- a  input  WIDTH  operand A (unsigned, or two's complement when overflow is enabled).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow flag. Present only with ADDER_OVERFLOW_EN.

## Operation
- Segment width SEG = WIDTH/STAGES. Stage k (0..STAGES-1) computes bits [k·SEG +: SEG] from the skewed operand segments and the carry registered by stage k-1. Stage 0 uses cin.
- Each stage register holds:
  - a valid bit;
  - the completed low sum segments;
  - the not-yet-added upper operand segments;
  - the inter-stage carry.
- Global advance enable: adv = !out_valid || out_ready. When adv is 1, every stage register loads from its predecessor and stage 0 loads {in_valid, operands}. When adv is 0, all stages hold.
- in_ready = adv (combinational). A beat transfers when in_valid && in_ready. The output transfers when out_valid && out_ready.
- Bubbles (in_valid = 0 while adv = 1) propagate as invalid stages. They are not collapsed.
- Data registers capture even when their valid bit is 0. The sum, cout and overflow values are don't-care while out_valid = 0, except after reset.
- Results leave in input order; no beat is dropped or duplicated.
- Arithmetic: {cout, sum} = a + b + cin, computed exactly at (WIDTH+1) bits.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert handled upstream): all valid bits go to 0. out_valid = 0, sum = 0, cout = 0, overflow = 0. in_ready is therefore 1.
- Latency: a beat accepted at edge N is presented with out_valid = 1 after edge N+STAGES-1. Its result is visible in the cycle following that edge, giving STAGES cycles of register delay.
- Throughput: 1 beat/cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, in_ready = 0 and every stage holds. sum, cout and overflow stay stable.
- Simultaneous output pop and input push in the same cycle is legal and sustains full rate.
- Reset mid-operation: all in-flight beats are discarded immediately, with no result emitted. The first beat after reset release follows normal latency.
- STAGES = 1 degenerates to a single registered adder with latency 1.

## Configuration
- ADDER_OVERFLOW_EN defined:
  - the overflow port exists;
  - the final stage also registers overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), with the operand sign bits carried through the pipeline;
  - overflow is valid only with out_valid.
- ADDER_OVERFLOW_EN undefined: no overflow port, no sign-bit pipeline registers. Behaviour is otherwise identical.

## Test plan
- WIDTH=4, STAGES=2, out_ready=1: drive all 512 {a,b,cin} combinations back-to-back. Every output must equal a+b+cin, in order, 2 cycles after acceptance, with out_valid continuously 1 after the fill.
- WIDTH=32, STAGES=4: a=0xFFFFFFFF, b=0, cin=1 → sum=0x00000000, cout=1, exactly 4 cycles later. Then a=0x0000FFFF, b=0x00000001, cin=0 → sum=0x00010000, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles with 6 beats offered. The pipeline fills, then in_ready=0 and sum stays constant. On release, all accepted beats emerge in order with none lost.
- Reset mid-flight: assert rst asynchronously (between edges) with 3 beats in flight. out_valid drops to 0 immediately and sum=0. None of the 3 results ever appear after release.
- Bubbles: alternate in_valid 1/0. out_valid toggles with the same pattern, delayed by STAGES cycles.
- ADDER_OVERFLOW_EN: 0x7FFFFFFF+0x00000001 → overflow=1. 0x80000000+0xFFFFFFFF → overflow=1, cout=1. 0x00000005+0xFFFFFFFE → overflow=0.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ripple-carry adder with its carry chain cut into
// STAGES equal segments, one register boundary per segment, valid/ready on
// both sides. Optional signed-overflow output is built when the macro
// ADDER_OVERFLOW_EN is defined; the default build has no overflow port.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are 1. The whole pipeline advances as one unit when the
// output slot is empty or being drained (adv = !out_valid || out_ready), so
// in_ready is exactly adv and nothing inside the pipe moves while it is 0.
// Valid never depends on ready on the input side; out_valid is registered.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int SEG = WIDTH / STAGES;

  // Per-stage registers: valid flag, partially completed sum, the operands
  // (only segments above the stage's carry position are consumed further
  // down), and the carry leaving the segment just added.
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [STAGES-1:0][WIDTH-1:0] opa_q, opa_d;
  logic [STAGES-1:0][WIDTH-1:0] opb_q, opb_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic                         adv;

  // Adds segment k of the operands plus the incoming carry and merges it into
  // the partial sum; returns {carry_out, merged_sum}.
  function automatic logic [WIDTH:0] seg_add(
    input logic [WIDTH-1:0] op_a,
    input logic [WIDTH-1:0] op_b,
    input logic [WIDTH-1:0] part,
    input logic             c,
    input int               k
  );
    logic [SEG:0]     r;
    logic [WIDTH-1:0] s;
    r = {1'b0, op_a[k*SEG +: SEG]} + {1'b0, op_b[k*SEG +: SEG]} + {{SEG{1'b0}}, c};
    s = part;
    s[k*SEG +: SEG] = r[SEG-1:0];
    return {r[SEG], s};
  endfunction

  // Global advance: the pipe moves only when the last stage can hand off.
  always_comb begin
    adv = !valid_q[STAGES-1] || out_ready;
  end

  assign in_ready = adv;

  // Next contents of every stage: stage 0 from the input port, stage k from
  // stage k-1, each adding its own segment.
  always_comb begin
    valid_d = '0;
    sum_d   = '0;
    opa_d   = '0;
    opb_d   = '0;
    carry_d = '0;

    valid_d[0] = in_valid;
    opa_d[0]   = a;
    opb_d[0]   = b;
    {carry_d[0], sum_d[0]} = seg_add(a, b, {WIDTH{1'b0}}, cin, 0);

    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      opa_d[k]   = opa_q[k-1];
      opb_d[k]   = opb_q[k-1];
      {carry_d[k], sum_d[k]} = seg_add(opa_q[k-1], opb_q[k-1], sum_q[k-1],
                                       carry_q[k-1], k);
    end
  end

  // Stage registers: cleared by reset, loaded together on advance, otherwise held.
  // Data fields load regardless of their valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      sum_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= '0;
    end else if (adv) begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
    end
  end

  // The last stage's operand copy has no consumer; it is kept only so every
  // stage has the same shape.
  logic unused_last_ops;
  assign unused_last_ops = ^{opa_q[STAGES-1], opb_q[STAGES-1]};

`ifdef ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Signed overflow of the finished sum, evaluated as the final stage loads;
  // the operand sign bits ride along in the operand registers.
  always_comb begin
    ovf_d = (opa_d[STAGES-1][WIDTH-1] == opb_d[STAGES-1][WIDTH-1]) &&
            (sum_d[STAGES-1][WIDTH-1] != opa_d[STAGES-1][WIDTH-1]);
  end

  // Overflow register shares the final stage's reset and advance behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: a 32-bit/4-stage instance for directed, stall,
// reset, bubble and random traffic, and a 4-bit/2-stage instance driven with
// every {a,b,cin} combination. Expected results come from plain integer
// addition and are queued at acceptance; monitors pop and compare on output.
module tb_pipelined_adder;

  localparam int W  = 32;
  localparam int S  = 4;
  localparam int W2 = 4;
  localparam int S2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0]  a, b, sum;
  logic          in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2;
  logic [W2-1:0] a2, b2, sum2;
  logic          act_ovf, act_ovf2;
`ifdef ADDER_OVERFLOW_EN
  logic          overflow, overflow2;
  assign act_ovf  = overflow;
  assign act_ovf2 = overflow2;
`else
  assign act_ovf  = 1'b0;
  assign act_ovf2 = 1'b0;
`endif

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef ADDER_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  pipelined_adder #(.WIDTH(W2), .STAGES(S2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2)
`ifdef ADDER_OVERFLOW_EN
    , .overflow(overflow2)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [W+1:0]  exp_q[$];   // {overflow, cout, sum}
  int            acc_q[$];   // edge index at which the beat was accepted
  logic [W2+1:0] exp2_q[$];
  int            acc2_q[$];
  bit            acc_hist[1024];
  bit            lat_chk = 0;
  bit            bub_chk = 0;
  bit            stall_prev = 0;
  bit            seen2 = 0;
  logic [W:0]    prev_out;
  int            out_seen = 0;
  int            sent_cnt = 0;
  bit            done = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  // Reference: exact (W+1)-bit integer sum, plus the signed-overflow rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return {(x[W-1] == y[W-1]) && (t[W-1] != x[W-1]), t};
  endfunction

  function automatic logic [W2+1:0] model2(input logic [W2-1:0] x, input logic [W2-1:0] y, input logic c);
    logic [W2:0] t;
    t = {1'b0, x} + {1'b0, y} + {{W2{1'b0}}, c};
    return {(x[W2-1] == y[W2-1]) && (t[W2-1] != x[W2-1]), t};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitors: big DUT ----------------
  always @(negedge clk) begin
    if (!rst) begin
      acc_hist[(cyc + 1) % 1024] <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  always @(negedge clk) begin
    logic [W+1:0] e;
    int           ac;
    if (!rst) begin
      if (bub_chk) check("bubble_pattern", out_valid, acc_hist[(cyc - (S - 1)) % 1024]);
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        if (stall_prev) check("stall_hold", {cout, sum}, prev_out);
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = {cout, sum};
      if (out_valid && out_ready) begin
        out_seen++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected no output (cycle %0d)", {cout, sum}, cyc);
        end else begin
          e  = exp_q.pop_front();
          ac = acc_q.pop_front();
`ifndef ADDER_OVERFLOW_EN
          e[W+1] = 1'b0;
`endif
          check("result", {act_ovf, cout, sum}, e);
          if (lat_chk) check("latency", cyc - ac, S - 1);
        end
      end
    end
  end

  // ---------------- monitors: small DUT ----------------
  always @(negedge clk) begin
    if (!rst && in_valid2 && in_ready2) begin
      exp2_q.push_back(model2(a2, b2, cin2));
      acc2_q.push_back(cyc + 1);
    end
  end

  always @(negedge clk) begin
    logic [W2+1:0] e;
    int            ac;
    if (!rst) begin
      if (out_valid2 && out_ready2) begin
        if (exp2_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output2: got %0h expected no output (cycle %0d)", {cout2, sum2}, cyc);
        end else begin
          e  = exp2_q.pop_front();
          ac = acc2_q.pop_front();
`ifndef ADDER_OVERFLOW_EN
          e[W2+1] = 1'b0;
`endif
          check("result2", {act_ovf2, cout2, sum2}, e);
          check("latency2", cyc - ac, S2 - 1);
          seen2 = 1;
        end
      end
      if (seen2 && exp2_q.size() > 0) check("stream_gap2", out_valid2, 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n = 0;
    in_valid = 1'b1; a = x; b = y; cin = c;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 500 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [W2-1:0] x, input logic [W2-1:0] y, input logic c);
    int n = 0;
    in_valid2 = 1'b1; a2 = x; b2 = y; cin2 = c;
    @(negedge clk);
    while (!in_ready2 && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready2) begin
      n_tests++;
      n_fail++;
      $display("FAIL send2_timeout: got in_ready=0 expected 1 within 500 cycles");
    end
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || exp2_q.size() > 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", exp_q.size() + exp2_q.size(), 0);
  endtask

  // Isolated beat: nothing visible after S-1 edges' worth minus one, result after S-1 edges.
  task automatic send_check(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            input logic [W-1:0] es, input logic ec, input logic eo);
    send(x, y, c);                  // returns just after acceptance edge N
    repeat (S - 2) @(posedge clk);  // edge N+S-2
    #1;
    check("dir_not_early", out_valid, 0);
    @(posedge clk);                 // edge N+S-1
    #1;
    check("dir_valid", out_valid, 1);
    check("dir_sum", sum, es);
    check("dir_cout", cout, ec);
`ifdef ADDER_OVERFLOW_EN
    check("dir_overflow", overflow, eo);
`endif
    idle(1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int seen_before;
    in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 1;
    in_valid2 = 0; a2 = '0; b2 = '0; cin2 = 0; out_ready2 = 1;

    // Power-on reset and reset-state checks.
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ovf", act_ovf, 0);
    check("rst_out_valid2", out_valid2, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    // Directed vectors with exact latency.
    lat_chk = 1;
    send_check(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    send_check(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    send_check(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send_check(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    send_check(32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 32'h0000_0003, 1'b1, 1'b0);
    drain();
    lat_chk = 0;

    // Every 4-bit combination back-to-back on the small instance.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = i[8:0];
      send2(v[3:0], v[7:4], v[8]);
    end
    drain();

    // Backpressure: six beats offered while the consumer stalls.
    sent_cnt = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send($urandom(), $urandom(), 1'($urandom_range(0, 1)));
          sent_cnt++;
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        check("stall_accepted", sent_cnt, S);
        check("stall_full_valid", out_valid, 1);
        check("stall_full_ready", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset while a full pipe is stalled: nothing in flight may ever emerge.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom(), $urandom(), 1'($urandom_range(0, 1)));
    @(posedge clk);
    #3;
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    acc_q.delete();
    stall_prev = 0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    seen_before = out_seen;
    idle(8);
    check("post_rst_no_output", out_seen - seen_before, 0);
    lat_chk = 1;
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    drain();

    // Bubbles: alternate valid / idle; out_valid must echo the pattern.
    idle(S + 1);
    bub_chk = 1;
    for (int i = 0; i < 8; i++) begin
      send($urandom(), $urandom(), 1'($urandom_range(0, 1)));
      idle(1);
    end
    idle(S + 1);
    bub_chk = 0;
    lat_chk = 0;
    drain();

    // Random traffic with random consumer backpressure.
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int gap;
          send($urandom(), $urandom(), 1'($urandom_range(0, 1)));
          gap = $urandom_range(0, 2);
          idle(gap);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
